// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and the serial comparator state encoding.
package alu_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/alu_seq_compare.sv
// Bit-serial MSB-first magnitude/equality comparator with start/busy/done handshake.
// Produces registered eq/gt/lt flags for the ALU status register.
module alu_seq_compare
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntTop = CntW'(WIDTH - 1);

  cmp_state_e      state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ssgn_q, ssgn_d;
  logic             found_q, found_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic a_msb, bit_eq, last_bit, top_bit;

  assign a_msb    = sa_q[WIDTH-1];
  assign bit_eq   = ~(sa_q[WIDTH-1] ^ sb_q[WIDTH-1]);
  assign last_bit = (cnt_q == '0);
  assign top_bit  = (cnt_q == CntTop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      ssgn_q  <= 1'b0;
      found_q <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      ssgn_q  <= ssgn_d;
      found_q <= found_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    ssgn_d  = ssgn_q;
    found_d = found_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sa_d    = a_i;
          sb_d    = b_i;
          ssgn_d  = sgn_i;
          cnt_d   = CntTop;
          found_d = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (found_q) begin
          // Fixed-latency mode: result already decided, just run out the count.
          if (last_bit) state_d = StDone;
        end else if (bit_eq) begin
          if (last_bit) begin
            eq_d    = 1'b1;
            state_d = StDone;
          end
        end else begin
          found_d = 1'b1;
          // A set sign bit marks the smaller operand in two's complement.
          if (top_bit && ssgn_q) begin
            gt_d = ~a_msb;
            lt_d = a_msb;
          end else begin
            gt_d = a_msb;
            lt_d = ~a_msb;
          end
          if (EARLY_EXIT || last_bit) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
    eq_o   = eq_q;
    gt_o   = gt_q;
    lt_o   = lt_q;
  end

endmodule

// File: tb/tb_alu_seq_compare.sv
// Scoreboard bench for alu_seq_compare: one early-exit and one fixed-latency instance share stimulus.
module tb_alu_seq_compare;

  localparam int W = 8;

  typedef struct {
    logic [2:0] flags;  // {eq, gt, lt}
    int         k;
    int         acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   busy, done, eq, gt, lt;

  int   n_checks;
  int   n_errors;
  int   cyc;
  exp_t sbq [2][$];
  logic [2:0] last [2];

  alu_seq_compare #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .sgn_i  (sgn),
    .a_i    (a),
    .b_i    (b),
    .busy_o (busy[0]),
    .done_o (done[0]),
    .eq_o   (eq[0]),
    .gt_o   (gt[0]),
    .lt_o   (lt[0])
  );

  alu_seq_compare #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .sgn_i  (sgn),
    .a_i    (a),
    .b_i    (b),
    .busy_o (busy[1]),
    .done_o (done[1]),
    .eq_o   (eq[1]),
    .gt_o   (gt[1]),
    .lt_o   (lt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: flags from native compares, latency from first differing bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    logic g, l;
    e.k = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) begin
        e.k = W - i;
        break;
      end
    end
    if (s) begin
      g = ($signed(x) > $signed(y));
      l = ($signed(x) < $signed(y));
    end else begin
      g = (x > y);
      l = (x < y);
    end
    e.flags = {(x == y), g, l};
    e.acc   = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        sbq[d].delete();
        last[d] = 3'b000;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          if (sbq[d].size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sbq[d].pop_front();
            check(d == 0 ? "flags_ee" : "flags_fx", {eq[d], gt[d], lt[d]}, e.flags);
            check(d == 0 ? "latency_ee" : "latency_fx", cyc - e.acc, d == 0 ? e.k : W);
            check("done_busy", busy[d], 1'b1);
            last[d] = e.flags;
          end
        end else if (!busy[d]) begin
          check("idle_hold", {eq[d], gt[d], lt[d]}, last[d]);
          check("idle_pending", sbq[d].size(), 0);
        end else begin
          check("busy_pending", sbq[d].size() != 0, 1'b1);
          if (sbq[d].size() != 0 && cyc == sbq[d][0].acc) begin
            check("clear_on_accept", {eq[d], gt[d], lt[d]}, 3'b000);
          end
        end
        if (start && !busy[d]) begin
          exp_t e;
          e = model(a, b, sgn);
          e.acc = cyc + 1;
          sbq[d].push_back(e);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy != 2'b00) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", busy, 2'b00);
  endtask

  task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a     = x;
    b     = y;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operand changes after acceptance must not matter.
    a     = W'($urandom);
    b     = W'($urandom);
    sgn   = 1'($urandom);
    wait_idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sgn      = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_ee", {busy[0], done[0], eq[0], gt[0], lt[0]}, 5'b0);
    check("reset_out_fx", {busy[1], done[1], eq[1], gt[1], lt[1]}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cmp(8'hA5, 8'hA5, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0);
    run_cmp(8'h12, 8'h13, 1'b0);
    run_cmp(8'h80, 8'h01, 1'b1);
    run_cmp(8'hFE, 8'hFF, 1'b1);
    run_cmp(8'hF0, 8'h0F, 1'b0);
    run_cmp(8'h01, 8'h80, 1'b1);
    run_cmp(8'h7F, 8'h80, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_cmp(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Reset mid-scan: the fixed-latency instance is still scanning two cycles in.
    a     = 8'h00;
    b     = 8'hFF;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy_fx", busy[1], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ee", {busy[0], done[0], eq[0], gt[0], lt[0]}, 5'b0);
    check("async_reset_fx", {busy[1], done[1], eq[1], gt[1], lt[1]}, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // start held high with changing operands: accepts only from IDLE.
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a   = W'($urandom);
      b   = (i % 3 == 0) ? a : W'($urandom);
      sgn = 1'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_ee", sbq[0].size(), 0);
    check("final_queue_fx", sbq[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
